// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial ripple adder.
// Holds the controller state encoding and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_full_add_bit.sv
// Combinational one-bit full adder cell.
// This is the addition mirror of the lab's one-bit subtractor cell.
module full_add_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, WIDTH+1 cycles per add.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic             bitSum;
  logic             bitCarry;
  logic             lastBit;
  logic [WIDTH-1:0] opA_d;
  logic [WIDTH-1:0] opB_d;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] count_d;

  full_add_bit uAddCell (
    .a_i  (opA_q[0]),
    .b_i  (opB_q[0]),
    .ci_i (carry_q),
    .s_o  (bitSum),
    .co_o (bitCarry)
  );

  // Sum fills from the top so that after WIDTH shifts bit 0 lands in sum[0].
  assign sum_d   = {bitSum, sum_q[WIDTH-1:1]};
  assign opA_d   = {1'b0, opA_q[WIDTH-1:1]};
  assign opB_d   = {1'b0, opB_q[WIDTH-1:1]};
  assign count_d = count_q + CNT_W'(1);
  assign lastBit = (count_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            opA_q   <= a_i;
            opB_q   <= b_i;
            carry_q <= cin_i;
            count_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          opA_q   <= opA_d;
          opB_q   <= opB_d;
          carry_q <= bitCarry;
          count_q <= count_d;
          // Flags are captured on the MSB step so they are valid alongside done.
          if (lastBit) begin
            cout_q  <= bitCarry;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= carry_q ^ bitCarry;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: scoreboard of expected sums, directed steps.
// Overflow checks are compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acceptCycle;
  } exp_t;

  exp_t sb[$];

  int checks        = 0;
  int errors        = 0;
  int cycleCount    = 0;
  int doneCount     = 0;
  int lastDoneCycle = 0;

  serial_add #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Independent tally of done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input bit expectResult);
    logic [W:0] total;
    exp_t       e;
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    if (expectResult) begin
      total         = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      e.sum         = total[W-1:0];
      e.cout        = total[W];
      e.ovf         = (av[W-1] == bv[W-1]) && (total[W-1] != av[W-1]);
      e.acceptCycle = cycleCount + 1;
      sb.push_back(e);
    end
    cycle();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    cin   = ~cv;
  endtask

  task automatic checkOutput(input string tag);
    int   n = 0;
    exp_t e;
    e.sum = 'x;
    e.cout = 1'bx;
    e.ovf = 1'bx;
    e.acceptCycle = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      cycle();
      n++;
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".sbSize"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, ".sum"}, 32'(sum), 32'(e.sum));
    check({tag, ".cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    // Edges from the accepting edge to done equal WIDTH, i.e. WIDTH+1 cycles.
    check({tag, ".latency"}, 32'(cycleCount - e.acceptCycle), 32'(W));
    lastDoneCycle = cycleCount;
    cycle();
    check({tag, ".donePulse"}, 32'(done), 32'd0);
    check({tag, ".idleBusy"}, 32'(busy), 32'd0);
    check({tag, ".sumHeld"}, 32'(sum), 32'(e.sum));
  endtask

  initial begin
    int doneBefore;
    int firstDone;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    cycle();
    cycle();
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    cycle();

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1);
    check("t1.runBusy", 32'(busy), 32'd1);
    checkOutput("t1_5A_3C");

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    checkOutput("t2_FF_01");

    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("t3_FF_FF_c1");

    // Abort in the fourth RUN cycle; the previous cout of 1 must clear too.
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    doneBefore = doneCount;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    repeat (2 * W) cycle();
    check("abort.noDone", 32'(doneCount), 32'(doneBefore));

    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1);
    checkOutput("t4_after_abort");

    // Start pulsed in the third RUN cycle must be ignored.
    doneBefore = doneCount;
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    cycle();
    cycle();
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    checkOutput("t5_ignore");
    repeat (2 * W) cycle();
    check("ignore.oneDone", 32'(doneCount - doneBefore), 32'd1);
    check("ignore.sbEmpty", 32'(sb.size()), 32'd0);
    check("ignore.sumKept", 32'(sum), 32'h30);

`ifdef SERIAL_ADD_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    checkOutput("ovf_7F_01");
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);
    checkOutput("ovf_80_80");
    applyStimulus(8'h10, 8'h10, 1'b0, 1'b1);
    checkOutput("ovf_10_10");
`endif

    applyStimulus(8'h12, 8'h34, 1'b1, 1'b1);
    checkOutput("b2b_first");
    firstDone = lastDoneCycle;
    applyStimulus(8'hC8, 8'h64, 1'b0, 1'b1);
    checkOutput("b2b_second");
    check("b2b.gap", 32'(lastDoneCycle - firstDone), 32'(W + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
